// File: rtl/perips_icb_bridge_pkg.sv
// Shared definitions for the core-to-peripheral ICB bridge.
package perips_icb_bridge_pkg;

    // Width of the address handed to the peripheral region.
    localparam int PERIPS_AW = 20;

    // Default value of the upper address bits selecting the peripheral region.
    localparam logic [11:0] DEF_REGION_BASE = 12'h100;

    // Bridge FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RESP = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/perips_icb_bridge.sv
// Core valid/ready request to peripheral ICB strobe bridge.
// One outstanding transaction; strobes are held until ack or timeout, and
// requests outside the peripheral region are answered with an error locally.
module perips_icb_bridge
    import perips_icb_bridge_pkg::*;
#(
    parameter logic [11:0] REGION_BASE = DEF_REGION_BASE,
    parameter int          TIMEOUT     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_vld,
    output logic                 req_rdy,
    input  logic                 req_we,
    input  logic [31:0]          req_adr,
    input  logic [31:0]          req_wdat,
    output logic                 rsp_vld,
    output logic                 rsp_err,
    output logic [31:0]          rsp_rdat,
    output logic                 icb_wr,
    output logic [PERIPS_AW-1:0] icb_wadr,
    output logic [31:0]          icb_wdat,
    input  logic                 icb_wack,
    output logic                 icb_rd,
    output logic [PERIPS_AW-1:0] icb_radr,
    input  logic [31:0]          icb_rdat,
    input  logic                 icb_rack
);

    // The counter leaves WR/RD at TIMEOUT-1, so it never needs to wrap.
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    bridge_state_e        state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 wr_nxt, rd_nxt;
    logic [PERIPS_AW-1:0] wadr_nxt, radr_nxt;
    logic [31:0]          wdat_nxt;
    logic                 vld_nxt, err_nxt;
    logic [31:0]          rdat_nxt;

    assign req_rdy = (state == ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state, strobe, counter and response logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_nxt    = icb_wr;
        rd_nxt    = icb_rd;
        wadr_nxt  = icb_wadr;
        radr_nxt  = icb_radr;
        wdat_nxt  = icb_wdat;
        vld_nxt   = 1'b0;
        err_nxt   = rsp_err;
        rdat_nxt  = rsp_rdat;
        case (state)
            ST_IDLE: begin
                err_nxt  = 1'b0;
                rdat_nxt = '0;
                if (req_vld && req_rdy) begin
                    wadr_nxt = req_adr[PERIPS_AW-1:0];
                    radr_nxt = req_adr[PERIPS_AW-1:0];
                    wdat_nxt = req_wdat;
                    cnt_nxt  = '0;
                    if (req_adr[31:PERIPS_AW] != REGION_BASE) begin
                        // Outside the region: answer locally, no ICB traffic.
                        state_nxt = ST_RESP;
                        vld_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                    end else if (req_we) begin
                        state_nxt = ST_WR;
                        wr_nxt    = 1'b1;
                    end else begin
                        state_nxt = ST_RD;
                        rd_nxt    = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // Ack has priority over a timeout in the same cycle.
                if (icb_wack) begin
                    wr_nxt    = 1'b0;
                    err_nxt   = 1'b0;
                    vld_nxt   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (cnt == CNT_LAST) begin
                    wr_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                    vld_nxt   = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RD: begin
                if (icb_rack) begin
                    rd_nxt    = 1'b0;
                    err_nxt   = 1'b0;
                    rdat_nxt  = icb_rdat;
                    vld_nxt   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (cnt == CNT_LAST) begin
                    rd_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                    rdat_nxt  = '0;
                    vld_nxt   = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RESP: begin
                // Single-cycle response, no backpressure.
                err_nxt   = 1'b0;
                rdat_nxt  = '0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobe, address, counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            icb_wr   <= 1'b0;
            icb_rd   <= 1'b0;
            icb_wadr <= '0;
            icb_radr <= '0;
            icb_wdat <= '0;
            rsp_vld  <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_rdat <= '0;
        end else begin
            cnt      <= cnt_nxt;
            icb_wr   <= wr_nxt;
            icb_rd   <= rd_nxt;
            icb_wadr <= wadr_nxt;
            icb_radr <= radr_nxt;
            icb_wdat <= wdat_nxt;
            rsp_vld  <= vld_nxt;
            rsp_err  <= err_nxt;
            rsp_rdat <= rdat_nxt;
        end
    end

endmodule
